// File: rtl/alert_mode_ctrl.sv
// -----------------------------------------------------------------------------
// alert_mode_ctrl
//
// Alert-mode controller feeding the piezo driver. Battery and wheel-speed
// samples are qualified with persistence counting and hysteresis, and the
// resulting flags select one of four modes. The three mode outputs are flop
// bits of a one-hot state register, so they are glitch-free and never more
// than one is high (priority ovr_spd > batt_low > norm_mode).
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   pwr_up    in   system powered; low forces IDLE and clears qualifiers
//   en_steer  in   rider on / steering enabled
//   batt      in   [11:0] unsigned battery sample
//   batt_vld  in   one-cycle strobe, batt valid
//   lft_spd   in   [11:0] signed left wheel speed
//   rght_spd  in   [11:0] signed right wheel speed
//   spd_vld   in   one-cycle strobe, both speeds valid
//   norm_mode out  normal riding indication
//   ovr_spd   out  over-speed alert
//   batt_low  out  low-battery alert
// -----------------------------------------------------------------------------
module alert_mode_ctrl #(
    parameter logic [11:0] BATT_THRESH = 12'h800,
    parameter logic [11:0] BATT_HYST   = 12'h040,
    parameter logic [10:0] SPD_THRESH  = 11'd1536,
    parameter logic [10:0] SPD_HYST    = 11'd128,
    parameter int          QUAL_CNT    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_up,
    input  logic        en_steer,
    input  logic [11:0] batt,
    input  logic        batt_vld,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        spd_vld,
    output logic        norm_mode,
    output logic        ovr_spd,
    output logic        batt_low
);

    localparam int CW = $clog2(QUAL_CNT + 1);
    localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL_CNT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Recovery level is a 13-bit sum so a large threshold plus margin cannot wrap.
    localparam logic [12:0] BATT_RECOV = {1'b0, BATT_THRESH} + {1'b0, BATT_HYST};
    // Clamped at zero so a mis-parameterised margin cannot wrap around.
    localparam logic [10:0] SPD_CLR = (SPD_HYST > SPD_THRESH) ? 11'd0 : (SPD_THRESH - SPD_HYST);

    // One-hot encoding: each mode output is a single flop bit of the state.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_NORM = 3'b001,
        ST_BATT = 3'b010,
        ST_OVR  = 3'b100
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic            bq_r;
    logic            sq_r;
    logic [CW-1:0]   bcnt_r;
    logic [CW-1:0]   scnt_r;
    logic [10:0]     lft_mag_s;
    logic [10:0]     rght_mag_s;
    logic [10:0]     mag_s;
    logic            batt_qual_s;
    logic            spd_qual_s;

    // Saturating absolute value: -2048 has no positive 12-bit twin, so it maps to 2047.
    function automatic logic [10:0] abs_sat(input logic [11:0] v);
        logic [10:0] res;
        if (!v[11]) begin
            res = v[10:0];
        end else if (v == 12'h800) begin
            res = 11'h7FF;
        end else begin
            res = 11'(12'd0 - v);
        end
        return res;
    endfunction

    // Speed magnitude and per-flag qualifying conditions (direction depends on flag).
    always_comb begin
        lft_mag_s   = abs_sat(lft_spd);
        rght_mag_s  = abs_sat(rght_spd);
        mag_s       = (lft_mag_s > rght_mag_s) ? lft_mag_s : rght_mag_s;
        batt_qual_s = 1'b0;
        spd_qual_s  = 1'b0;
        if (bq_r) begin
            batt_qual_s = ({1'b0, batt} >= BATT_RECOV);
        end else begin
            batt_qual_s = (batt < BATT_THRESH);
        end
        if (sq_r) begin
            spd_qual_s = (mag_s < SPD_CLR);
        end else begin
            spd_qual_s = (mag_s > SPD_THRESH);
        end
    end

    // Battery qualifier: a run of QUAL_CNT qualifying strobes toggles bq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bq_r   <= 1'b0;
            bcnt_r <= CNT_ZERO;
        end else if (!pwr_up) begin
            bq_r   <= 1'b0;
            bcnt_r <= CNT_ZERO;
        end else if (batt_vld) begin
            if (batt_qual_s) begin
                if (bcnt_r == QUAL_LAST) begin
                    bq_r   <= ~bq_r;
                    bcnt_r <= CNT_ZERO;
                end else begin
                    bcnt_r <= bcnt_r + CNT_ONE;
                end
            end else begin
                bcnt_r <= CNT_ZERO;
            end
        end else begin
            bcnt_r <= bcnt_r;
        end
    end

    // Speed qualifier: same scheme, but dropping en_steer clears it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_r   <= 1'b0;
            scnt_r <= CNT_ZERO;
        end else if (!pwr_up || !en_steer) begin
            sq_r   <= 1'b0;
            scnt_r <= CNT_ZERO;
        end else if (spd_vld) begin
            if (spd_qual_s) begin
                if (scnt_r == QUAL_LAST) begin
                    sq_r   <= ~sq_r;
                    scnt_r <= CNT_ZERO;
                end else begin
                    scnt_r <= scnt_r + CNT_ONE;
                end
            end else begin
                scnt_r <= CNT_ZERO;
            end
        end else begin
            scnt_r <= scnt_r;
        end
    end

    // Next mode from the priority chain; any state may jump to any other.
    always_comb begin
        next_s = ST_IDLE;
        if (!pwr_up) begin
            next_s = ST_IDLE;
        end else if (sq_r) begin
            next_s = ST_OVR;
        end else if (bq_r) begin
            next_s = ST_BATT;
        end else if (en_steer) begin
            next_s = ST_NORM;
        end else begin
            next_s = ST_IDLE;
        end
    end

    // Mode register; its one-hot bits are the registered piezo requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    assign norm_mode = state_r[0];
    assign batt_low  = state_r[1];
    assign ovr_spd   = state_r[2];

endmodule

// File: tb/tb_alert_mode_ctrl.sv
module tb_alert_mode_ctrl;

    localparam int QC = 4;
    localparam int BT = 2048;
    localparam int BH = 64;
    localparam int ST = 1536;
    localparam int SH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwr_up;
    logic        en_steer;
    logic [11:0] batt;
    logic        batt_vld;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        spd_vld;
    logic        norm_mode;
    logic        ovr_spd;
    logic        batt_low;

    always #5 clk = ~clk;

    alert_mode_ctrl #(.QUAL_CNT(QC)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwr_up   (pwr_up),
        .en_steer (en_steer),
        .batt     (batt),
        .batt_vld (batt_vld),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld),
        .norm_mode(norm_mode),
        .ovr_spd  (ovr_spd),
        .batt_low (batt_low)
    );

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    // Reference state: plain integers following the qualification rules.
    int m_bq, m_sq, m_bcnt, m_scnt;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {ovr,batt,norm}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mag_of(input logic [11:0] v);
        int s;
        s = $signed(v);
        if (s < 0) s = -s;
        if (s > 2047) s = 2047;
        return s;
    endfunction

    // Reference model: at each rising edge the expected outputs after that edge
    // follow from the flags held before it; flags then update from the sampled inputs.
    initial begin
        logic [2:0] e;
        int mag;
        bit qual;
        m_bq = 0; m_sq = 0; m_bcnt = 0; m_scnt = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_bq = 0; m_sq = 0; m_bcnt = 0; m_scnt = 0;
                e = 3'b000;
            end else begin
                if (!pwr_up)       e = 3'b000;
                else if (m_sq != 0) e = 3'b100;
                else if (m_bq != 0) e = 3'b010;
                else if (en_steer)  e = 3'b001;
                else                e = 3'b000;
                if (!pwr_up) begin
                    m_bq = 0; m_sq = 0; m_bcnt = 0; m_scnt = 0;
                end else begin
                    if (batt_vld) begin
                        qual = (m_bq != 0) ? (int'(batt) >= BT + BH) : (int'(batt) < BT);
                        if (qual) begin
                            m_bcnt++;
                            if (m_bcnt == QC) begin m_bq = 1 - m_bq; m_bcnt = 0; end
                        end else m_bcnt = 0;
                    end
                    if (!en_steer) begin
                        m_sq = 0; m_scnt = 0;
                    end else if (spd_vld) begin
                        mag = mag_of(lft_spd);
                        if (mag_of(rght_spd) > mag) mag = mag_of(rght_spd);
                        qual = (m_sq != 0) ? (mag < ST - SH) : (mag > ST);
                        if (qual) begin
                            m_scnt++;
                            if (m_scnt == QC) begin m_sq = 1 - m_sq; m_scnt = 0; end
                        end else m_scnt = 0;
                    end
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares the DUT outputs against the oldest expectation each falling edge.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("mode_outputs", {ovr_spd, batt_low, norm_mode}, e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bsample(input logic [11:0] v);
        batt = v; batt_vld = 1'b1;
        @(negedge clk);
        batt_vld = 1'b0;
    endtask

    task automatic ssample(input int l, input int r);
        lft_spd = 12'(l); rght_spd = 12'(r); spd_vld = 1'b1;
        @(negedge clk);
        spd_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pwr_up = 1'b0; en_steer = 1'b0;
        batt = 12'h900; batt_vld = 1'b0;
        lft_spd = 12'd0; rght_spd = 12'd0; spd_vld = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        pwr_up = 1'b1; en_steer = 1'b1;
        idle(3);
        // Battery low, hysteresis band, recovery.
        repeat (4) bsample(12'h7F0);
        idle(3);
        repeat (4) bsample(12'h820);
        idle(3);
        repeat (4) bsample(12'h840);
        idle(3);
        // Over-speed pre-empts battery; en_steer fall returns to battery.
        repeat (4) bsample(12'h7F0);
        idle(3);
        repeat (4) ssample(-1600, 0);
        idle(3);
        en_steer = 1'b0;
        idle(4);
        en_steer = 1'b1;
        repeat (4) bsample(12'h840);
        idle(3);
        // Interrupted speed run restarts.
        ssample(1600, 0); ssample(1600, 0); ssample(1600, 0); ssample(1500, 0);
        idle(2);
        repeat (4) ssample(0, 1600);
        idle(3);
        repeat (4) ssample(0, 0);
        idle(3);
        // Saturating magnitude of -2048.
        repeat (4) ssample(-2048, 0);
        idle(3);
        repeat (4) ssample(100, -100);
        idle(3);
        // Simultaneous qualifying strobes, then power drop and a fresh run.
        repeat (4) begin
            batt = 12'h7F0; batt_vld = 1'b1;
            lft_spd = 12'(1600); rght_spd = 12'(0); spd_vld = 1'b1;
            @(negedge clk);
            batt_vld = 1'b0; spd_vld = 1'b0;
        end
        idle(3);
        pwr_up = 1'b0;
        idle(2);
        pwr_up = 1'b1;
        idle(2);
        repeat (3) ssample(1600, 0);
        idle(3);
        ssample(1600, 0);
        idle(3);
        // Asynchronous reset while in OVR.
        @(negedge clk);
        #2;
        check("pre_reset_ovr", {ovr_spd, batt_low, norm_mode}, 3'b100);
        rst_n = 1'b0;
        #1;
        check("async_reset", {ovr_spd, batt_low, norm_mode}, 3'b000);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        // Randomized phase with values clustered around the thresholds.
        for (int i = 0; i < 3000; i++) begin
            pwr_up   = ($urandom_range(0, 149) != 0);
            en_steer = ($urandom_range(0, 29) != 0);
            batt_vld = $urandom_range(0, 1) == 1;
            batt     = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(12'h7C0, 12'h880));
            spd_vld  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) lft_spd = 12'h800;
            else lft_spd = 12'(($urandom_range(0, 1) == 1 ? -1 : 1) * int'($urandom_range(1300, 1700)));
            rght_spd = 12'(($urandom_range(0, 1) == 1 ? -1 : 1) * int'($urandom_range(0, 1700)));
            @(negedge clk);
        end
        batt_vld = 1'b0; spd_vld = 1'b0;
        idle(3);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alert_mode_ctrl.md
# alert_mode_ctrl

Alert-mode controller that sits directly upstream of the piezo driver. It qualifies battery-voltage and wheel-speed samples from the A2D/balance path with persistence counting and hysteresis. From those it drives the three mode flags the piezo consumes: `norm_mode`, `ovr_spd` and `batt_low`. Outputs are registered, glitch-free and at most one-hot, with priority ovr_spd > batt_low > norm_mode, so the piezo never sees conflicting requests.

## Interface
Parameters:
- `BATT_THRESH`, default 12'h800: battery-low threshold (unsigned A2D counts).
- `BATT_HYST`, default 12'h040: recovery margin; battery clears only at `>= BATT_THRESH+BATT_HYST`.
- `SPD_THRESH`, default 11'd1536: over-speed threshold on unsigned speed magnitude.
- `SPD_HYST`, default 11'd128: recovery margin; over-speed clears only at `< SPD_THRESH-SPD_HYST`.
- `QUAL_CNT`, default 256: consecutive qualifying samples required to set or clear a flag (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pwr_up`  in  1  system powered; low forces IDLE and clears all qualification state.
- `en_steer`  in  1  rider on and steering enabled.
- `batt`  in  12  unsigned battery sample.
- `batt_vld`  in  1  one-cycle strobe; `batt` valid.
- `lft_spd`  in  12  signed left wheel speed.
- `rght_spd`  in  12  signed right wheel speed.
- `spd_vld`  in  1  one-cycle strobe; both speeds valid.
- `norm_mode`  out  1  normal-riding indication to piezo.
- `ovr_spd`  out  1  over-speed alert to piezo.
- `batt_low`  out  1  low-battery alert to piezo.

## Operation
- Speed magnitude: `mag = max(|lft_spd|, |rght_spd|)`, each abs saturating (-2048 → 2047), 11-bit unsigned result. Compare unsigned against 11-bit thresholds. `SPD_THRESH-SPD_HYST` is computed at elaboration and must not underflow.
- Battery qualifier: flag `bq` plus counter `bcnt`, width `$clog2(QUAL_CNT+1)`.
  - `bq=0`: each `batt_vld` with `batt < BATT_THRESH` increments `bcnt`; any other valid sample zeroes it. Reaching `QUAL_CNT` sets `bq` and zeroes `bcnt`.
  - `bq=1`: each valid sample with `batt >= BATT_THRESH+BATT_HYST` (13-bit sum, no wrap) increments `bcnt`; any other valid sample zeroes it. Reaching `QUAL_CNT` clears `bq` and zeroes `bcnt`.
  - Cycles without `batt_vld` hold `bcnt`.
- Speed qualifier: flag `sq` and counter `scnt`, same scheme on `spd_vld`.
  - Set condition: `mag > SPD_THRESH`.
  - Clear condition: `mag < SPD_THRESH-SPD_HYST`.
  - `en_steer=0` forces `sq=0` and `scnt=0` immediately, overriding any sample.
- `pwr_up=0` zeroes `bq`, `sq`, `bcnt`, `scnt`.
- FSM states: IDLE, NORM, BATT, OVR. Next state is evaluated every cycle in priority order:
  - `!pwr_up` → IDLE.
  - else `sq` → OVR.
  - else `bq` → BATT.
  - else `en_steer` → NORM.
  - else IDLE.
  - Any state can reach any state directly.
- Outputs are registered decodes of the next state: IDLE=000, NORM=`norm_mode`, BATT=`batt_low`, OVR=`ovr_spd`. They are never more than one high.
- `batt_vld` and `spd_vld` in the same cycle are handled independently.

## Timing
- Reset: state IDLE; `norm_mode=ovr_spd=batt_low=0`; counters and flags 0.
- Reset mid-operation clears everything asynchronously. The first post-reset transition is evaluated on the first rising edge with `rst_n` high.
- Qualifier latency: the edge that samples the `QUAL_CNT`-th qualifying strobe updates `bq`/`sq`. Outputs change on the following edge, i.e. 2 edges after that strobe's sampling edge in total.
- `en_steer` or `pwr_up` changes: outputs reflect them 1 edge later, except OVR exit on `en_steer` fall, which takes 2 edges (the `sq` clear, then output).
- `QUAL_CNT=1`: a single qualifying sample sets or clears the flag.
- A qualifying run interrupted by one non-qualifying sample restarts from 0.

## Test plan
(Bench overrides `QUAL_CNT=4`; other parameters at default.)
- Reset, then `pwr_up=1`, `en_steer=1`, no strobes → `norm_mode=1` exactly 1 edge after `en_steer` rises; other outputs 0.
- 4 `batt_vld` with `batt=12'h7F0`, `en_steer=1` → `batt_low=1`, `norm_mode=0` 2 edges after the 4th strobe. Then 4 samples of 12'h820 → no change. Then 4 samples of 12'h840 → back to `norm_mode`.
- While `batt_low`, 4 `spd_vld` with `lft_spd=-12'd1600`, `rght_spd=0` → `ovr_spd=1`, `batt_low=0`. Then drop `en_steer` → `ovr_spd=0`, `batt_low=1` 2 edges later.
- Speed run 1600, 1600, 1600, 1500, then 4×1600 → `ovr_spd` rises only after the final run. `lft_spd=-2048` reads as magnitude 2047 and qualifies.
- Simultaneous `batt_vld`/`spd_vld` both qualifying for 4 strobes → only `ovr_spd=1`. `pwr_up=0` → all outputs 0 next edge and counters cleared; re-raising `pwr_up` needs a full 4-sample run again.
- Assert `rst_n=0` asynchronously while in OVR → all outputs 0 immediately, without waiting for a clock edge.
